sha256_padder: RTL and testbench

Message front end for the SHA-256 datapath: accepts a raw byte-aligned message as 32-bit big-endian words, applies FIPS 180-4 padding, and writes complete 512-bit blocks, one 32-bit word per write, into the FIFO that the SHA-256 engine drains. It is the writer for that FIFO. The engine sees only whole, padded 16-word blocks.

---
 rtl/sha256_padder.sv | 103 ++++++++++
 tb/tb_sha256_padder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sha256_padder.sv
// sha256_padder: FIPS 180-4 padding front end writing whole 512-bit blocks into the SHA-256 FIFO.
// Optional SHA256_PADDER_BYTESWAP_EN byte-swaps incoming message words for little-endian masters.
module sha256_padder (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start_i,
  output logic        busy_o,
  input  logic        msg_valid_i,
  output logic        msg_ready_o,
  input  logic [31:0] msg_dat_i,
  input  logic        msg_last_i,
  input  logic [2:0]  msg_bytes_i,
  input  logic        fifo_afull_i,
  output logic        fifo_wr_en,
  output logic [31:0] fifo_wr_dat,
  output logic [15:0] blocks_o,
  output logic        done_o
);
  typedef enum logic [2:0] {IDLE, DATA, PAD80, ZERO, LENHI, LENLO} state_t;
  state_t state, state_n;
  logic [63:0] bits;
  logic [3:0] pos;
  logic [31:0] din, wdat;
  logic [2:0] n;
  logic [5:0] add;
  logic wr, hs, at14;
`ifdef SHA256_PADDER_BYTESWAP_EN
  assign din = {msg_dat_i[7:0], msg_dat_i[15:8], msg_dat_i[23:16], msg_dat_i[31:24]};
`else
  assign din = msg_dat_i;
`endif
  assign n = msg_bytes_i > 3'd4 ? 3'd4 : msg_bytes_i;
  assign msg_ready_o = state == DATA && !fifo_afull_i;
  assign hs = msg_valid_i && msg_ready_o;
  // the write happening now leaves pos at 14, so the length words come next
  assign at14 = pos == 4'd13;
  always_comb begin
    state_n = state;
    wr = 1'b0;
    wdat = '0;
    add = '0;
    case (state)
      IDLE: state_n = start_i ? DATA : IDLE;
      DATA: if (hs) begin
        wr = 1'b1;
        add = msg_last_i ? {n, 3'b000} : 6'd32;
        wdat = msg_last_i && n != 3'd4
             ? (din & ~(32'hFFFF_FFFF >> {n[1:0], 3'b000})) | (32'h8000_0000 >> {n[1:0], 3'b000})
             : din;
        if (msg_last_i) state_n = n == 3'd4 ? PAD80 : at14 ? LENHI : ZERO;
      end
      PAD80: if (!fifo_afull_i) begin
        wr = 1'b1;
        wdat = 32'h8000_0000;
        state_n = at14 ? LENHI : ZERO;
      end
      ZERO: if (!fifo_afull_i) begin
        wr = 1'b1;
        state_n = at14 ? LENHI : ZERO;
      end
      LENHI: if (!fifo_afull_i) begin
        wr = 1'b1;
        wdat = bits[63:32];
        state_n = LENLO;
      end
      LENLO: if (!fifo_afull_i) begin
        wr = 1'b1;
        wdat = bits[31:0];
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      bits <= '0;
      pos <= '0;
      busy_o <= 1'b0;
      fifo_wr_en <= 1'b0;
      fifo_wr_dat <= '0;
      blocks_o <= '0;
      done_o <= 1'b0;
    end else begin
      state <= state_n;
      fifo_wr_en <= wr;
      done_o <= state == LENLO && wr;
      if (wr) fifo_wr_dat <= wdat;
      if (state == IDLE && start_i) begin
        bits <= '0;
        pos <= '0;
        blocks_o <= '0;
        busy_o <= 1'b1;
      end
      if (wr) begin
        pos <= pos + 4'd1;
        bits <= bits + 64'(add);
        if (pos == 4'd15) blocks_o <= blocks_o + 16'd1;
      end
      if (state == LENLO && wr) busy_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed self-checking bench for sha256_padder against a byte-level padding model.
module tb_sha256_padder;
  logic clk = 0, rstn = 0, start_i = 0, msg_valid_i = 0, msg_last_i = 0, fifo_afull_i = 0;
  logic [31:0] msg_dat_i = 0;
  logic [2:0] msg_bytes_i = 0;
  logic busy_o, msg_ready_o, fifo_wr_en, done_o;
  logic [31:0] fifo_wr_dat;
  logic [15:0] blocks_o;
  int checks = 0, errors = 0, dones = 0;
  logic [31:0] got_q[$], exp_q[$];
  logic [7:0] msg_b[$];

  sha256_padder dut (
    .clk(clk), .rstn(rstn), .start_i(start_i), .busy_o(busy_o),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o), .msg_dat_i(msg_dat_i),
    .msg_last_i(msg_last_i), .msg_bytes_i(msg_bytes_i), .fifo_afull_i(fifo_afull_i),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_dat(fifo_wr_dat), .blocks_o(blocks_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (fifo_wr_en) got_q.push_back(fifo_wr_dat);
    if (done_o) dones++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 0);
    chk({tag, "_ready"}, 64'(msg_ready_o), 0);
    chk({tag, "_wr_en"}, 64'(fifo_wr_en), 0);
    chk({tag, "_done"}, 64'(done_o), 0);
    chk({tag, "_wr_dat"}, 64'(fifo_wr_dat), 0);
    chk({tag, "_blocks"}, 64'(blocks_o), 0);
  endtask

  // FIPS 180-4 padding computed bytewise, independent of the word-level datapath
  task automatic build_exp();
    logic [7:0] b[$];
    logic [63:0] len;
    b = msg_b;
    len = 64'(msg_b.size()) * 8;
    b.push_back(8'h80);
    while (b.size() % 64 != 56) b.push_back(8'h00);
    for (int k = 7; k >= 0; k--) b.push_back(len[8*k +: 8]);
    exp_q.delete();
    for (int i = 0; i < b.size(); i += 4) exp_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb, input logic poke);
    int t;
    t = 0;
    msg_valid_i = 1; msg_dat_i = d; msg_last_i = last; msg_bytes_i = nb; start_i = poke;
    while (!msg_ready_o && t < 100) begin @(negedge clk); t++; end
    chk("ready_timeout", 64'(t < 100), 1);
    @(negedge clk);
    msg_valid_i = 0; msg_last_i = 0; start_i = 0;
  endtask

  // unused bytes of the last word carry 0xFF so the masking is exercised
  task automatic send_msg(input logic [2:0] full_nb, input logic poke);
    int n, nw, nb;
    logic [31:0] d;
    n = msg_b.size();
    nw = n == 0 ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      d = 32'hFFFF_FFFF;
      nb = 0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < n) begin d[31 - 8*k -: 8] = msg_b[w*4 + k]; nb++; end
      send_word(d, w == nw - 1, nb == 4 ? full_nb : 3'(nb), poke && w == 2);
    end
  endtask

  task automatic fill(input int n);
    msg_b.delete();
    for (int i = 0; i < n; i++) msg_b.push_back(8'(i * 13 + 5));
  endtask

  task automatic do_msg(input string tag, input logic [2:0] full_nb, input logic poke, input logic stall);
    int t, n0;
    got_q.delete();
    dones = 0;
    build_exp();
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    chk({tag, "_busy_start"}, 64'(busy_o), 1);
    send_msg(full_nb, poke);
    if (stall) begin
      repeat (2) @(negedge clk);
      fifo_afull_i = 1;
      @(negedge clk);
      n0 = got_q.size();
      repeat (4) @(negedge clk);
      chk({tag, "_stall_writes"}, 64'(got_q.size()), 64'(n0));
      chk({tag, "_stall_wr_en"}, 64'(fifo_wr_en), 0);
      fifo_afull_i = 0;
    end
    t = 0;
    while (dones == 0 && t < 200) begin @(negedge clk); t++; end
    @(negedge clk);
    chk({tag, "_done_timeout"}, 64'(t < 200), 1);
    chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_blocks"}, 64'(blocks_o), 64'(exp_q.size() / 16));
    chk({tag, "_wr_vs_blocks"}, 64'(got_q.size()), 64'(blocks_o) * 16);
    chk({tag, "_done_once"}, 64'(dones), 1);
    chk({tag, "_busy_end"}, 64'(busy_o), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rstn = 1;
    @(negedge clk);

    fill(0);
    do_msg("empty", 3'd4, 0, 0);
    chk("empty_w0", 64'(got_q[0]), 64'h8000_0000);

    msg_b = '{8'h61, 8'h62, 8'h63};
    do_msg("abc", 3'd4, 0, 0);
    chk("abc_w0", 64'(got_q[0]), 64'h6162_6380);
    chk("abc_len", 64'(got_q[15]), 64'h18);

    fill(6);
    do_msg("six", 3'd4, 0, 0);
    fill(55);
    do_msg("b55", 3'd4, 0, 0);
    fill(57);
    do_msg("b57", 3'd4, 0, 0);

    fill(56);
    do_msg("w14", 3'd4, 1, 0);
    chk("w14_len", 64'(got_q[31]), 64'h1C0);

    fill(64);
    do_msg("w16", 3'd7, 0, 0);
    chk("w16_pad", 64'(got_q[16]), 64'h8000_0000);
    chk("w16_len", 64'(got_q[31]), 64'h200);

    fill(20);
    do_msg("stall", 3'd4, 0, 1);

    got_q.delete();
    fill(20);
    start_i = 1;
    @(negedge clk);
    start_i = 0;
    for (int w = 0; w < 5; w++) send_word({msg_b[4*w], msg_b[4*w+1], msg_b[4*w+2], msg_b[4*w+3]}, 0, 3'd4, 0);
    fifo_afull_i = 1;
    #1;
    chk("afull_ready", 64'(msg_ready_o), 0);
    fifo_afull_i = 0;
    rstn = 0;
    @(negedge clk);
    reset_checks("midrst");
    rstn = 1;
    @(negedge clk);
    msg_b = '{8'h61, 8'h62, 8'h63};
    do_msg("abc2", 3'd4, 0, 0);
    chk("abc2_w0", 64'(got_q[0]), 64'h6162_6380);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
